// File: rtl/rx_byte_fifo_pkg.sv
// Shared constants and helpers for the receive-side byte queue.
// Width/depth defaults match the deserializer and rs232c instances.
package rx_byte_fifo_pkg;

  localparam int RX_FIFO_WIDTH      = 8;
  localparam int RX_FIFO_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e make_op(input logic do_push, input logic do_pop);
    return fifo_op_e'({do_push, do_pop});
  endfunction

endpackage

// File: rtl/rx_byte_fifo_ram.sv
// Register array for the receive queue: one synchronous write port, one
// combinational read port. Contents are never cleared.
module rx_fifo_ram
  import rx_byte_fifo_pkg::*;
#(
  parameter int WIDTH      = RX_FIFO_WIDTH,
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte queue between the UART deserializer and the core.
// Define RX_FIFO_OVERFLOW_FLAG_EN to build the sticky rx_overflow flop; otherwise it reads 0.
module rx_byte_fifo
  import rx_byte_fifo_pkg::*;
#(
  parameter int WIDTH      = RX_FIFO_WIDTH,
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_enable,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  rx_fifo_pop,
  output logic [WIDTH-1:0]      rx_received_data,
  output logic                  rx_waiting,
  output logic                  rx_full,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  rx_overflow
);

  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] ONE_C   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE_C = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_s, full_s, do_pop_s, do_push_s, drop_s;
  logic [WIDTH-1:0]      head_s;

  assign empty_s   = (count_q == '0);
  assign full_s    = (count_q == DEPTH_C);
  // A pop on a non-empty full queue frees the slot the simultaneous push uses.
  assign do_pop_s  = rx_fifo_pop && !empty_s;
  assign do_push_s = push_enable && (!full_s || do_pop_s);
  assign drop_s    = push_enable && !do_push_s;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE_C;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case (make_op(do_push_s, do_pop_s))
      OP_PUSH: count_d = count_q + ONE_C;
      OP_POP:  count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  rx_fifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (do_push_s && !reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (push_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_s)
  );

  assign rx_received_data = empty_s ? '0 : head_s;
  assign rx_waiting       = empty_s;
  assign rx_full          = full_s;
  assign rx_count         = count_q;

`ifdef RX_FIFO_OVERFLOW_FLAG_EN
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop_s) begin
      overflow_q <= 1'b1;
    end
  end

  assign rx_overflow = overflow_q;
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
  assign rx_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Self-checking bench for rx_byte_fifo: a vector table plus hand sequences,
// with a byte-queue reference model acting as the scoreboard.
module tb_rx_byte_fifo;

`ifdef RX_FIFO_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push_enable = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       rx_fifo_pop = 1'b0;
  logic [7:0] rx_received_data;
  logic       rx_waiting, rx_full, rx_overflow;
  logic [4:0] rx_count;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] model_q[$];
  bit         ovf_m = 1'b0;

  rx_byte_fifo dut (
    .clk              (clk),
    .reset            (reset),
    .push_enable      (push_enable),
    .push_data        (push_data),
    .rx_fifo_pop      (rx_fifo_pop),
    .rx_received_data (rx_received_data),
    .rx_waiting       (rx_waiting),
    .rx_full          (rx_full),
    .rx_count         (rx_count),
    .rx_overflow      (rx_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"},   32'(rx_count), 32'(model_q.size()));
    chk({tag, ".waiting"}, 32'(rx_waiting), 32'(model_q.size() == 0));
    chk({tag, ".full"},    32'(rx_full), 32'(model_q.size() == 16));
    chk({tag, ".head"},    32'(rx_received_data), (model_q.size() == 0) ? 32'h0 : 32'(model_q[0]));
    chk({tag, ".ovf"},     32'(rx_overflow), 32'(ovf_m));
  endtask

  // One clock with the given inputs; the model is updated and the popped byte scored.
  task automatic step(input bit rst, input bit push, input logic [7:0] data, input bit pop);
    bit do_pop, do_push;
    reset = rst; push_enable = push; push_data = data; rx_fifo_pop = pop;
    if (rst) begin
      model_q.delete();
      ovf_m = 1'b0;
    end else begin
      do_pop  = pop && (model_q.size() > 0);
      do_push = push && ((model_q.size() < 16) || do_pop);
      #1;
      if (do_pop) begin
        chk("pop_data", 32'(rx_received_data), 32'(model_q[0]));
        void'(model_q.pop_front());
      end
      if (do_push) model_q.push_back(data);
      if (push && !do_push && OVF_EN) ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
    reset = 1'b0; push_enable = 1'b0; rx_fifo_pop = 1'b0;
  endtask

  typedef struct {
    bit         rst, push, pop;
    logic [7:0] data;
    logic [4:0] exp_count;
    bit         exp_waiting, exp_full;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h41, 5'd1, 1'b0, 1'b0, 8'h41};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h5A, 5'd1, 1'b0, 1'b0, 8'h5A};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 8'h11};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h22, 5'd2, 1'b0, 1'b0, 8'h11};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h33, 5'd2, 1'b0, 1'b0, 8'h22};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0, 1'b0, 8'h33};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].push, vecs[i].data, vecs[i].pop);
      chk($sformatf("vec%0d.count", i),   32'(rx_count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d.waiting", i), 32'(rx_waiting), 32'(vecs[i].exp_waiting));
      chk($sformatf("vec%0d.full", i),    32'(rx_full), 32'(vecs[i].exp_full));
      chk($sformatf("vec%0d.head", i),    32'(rx_received_data), 32'(vecs[i].exp_head));
      chk($sformatf("vec%0d.ovf", i),     32'(rx_overflow), 32'h0);
    end

    // Fill, simultaneous push+pop while full, drop on full, then drain across the wrap.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0);
      check_state($sformatf("fill%0d", i));
    end
    chk("full.flag", 32'(rx_full), 32'h1);
    chk("full.count", 32'(rx_count), 32'd16);
    step(1'b0, 1'b1, 8'hAA, 1'b1);
    chk("both_full.count", 32'(rx_count), 32'd16);
    chk("both_full.ovf", 32'(rx_overflow), 32'h0);
    chk("both_full.head", 32'(rx_received_data), 32'h01);
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    chk("drop.count", 32'(rx_count), 32'd16);
    chk("drop.ovf", 32'(rx_overflow), 32'(OVF_EN));
    check_state("drop");
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check_state($sformatf("drain%0d", i));
    end
    chk("drained.waiting", 32'(rx_waiting), 32'h1);

    // Reset mid-stream with a push and pop in the reset cycle.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    check_state("pre_rst");
    step(1'b1, 1'b1, 8'h77, 1'b1);
    chk("rst.count", 32'(rx_count), 32'd0);
    chk("rst.waiting", 32'(rx_waiting), 32'h1);
    chk("rst.ovf", 32'(rx_overflow), 32'h0);
    chk("rst.head", 32'(rx_received_data), 32'h00);
    step(1'b0, 1'b1, 8'h33, 1'b0);
    chk("post_rst.head", 32'(rx_received_data), 32'h33);
    chk("post_rst.count", 32'(rx_count), 32'd1);
    check_state("post_rst");

    // Random mix scored against the model.
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 2) == 0));
      check_state("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
